wm8731_i2c_responder: RTL and testbench

//  I2C target model of the WM8731 codec control port; the responder end of the AudioInit
//  I2C master link. Oversamples SCL/SDA on clock50, ACKs valid write frames and holds the

---
 rtl/wm8731_i2c_responder.sv | 154 +++++++++++++++
 tb/tb_wm8731_i2c_responder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/wm8731_i2c_responder.sv
// wm8731_i2c_responder: write-only WM8731 I2C control-port target holding the codec register file.
// Define WM8731_RESP_GLITCH_FILTER_EN to add a 4-sample spike filter on SCL/SDA after the synchronizer.
module wm8731_i2c_responder #(
  parameter logic [6:0] DEV_ADDR  = 7'h1A,
  parameter int         NUM_REGS  = 10,
  parameter logic [6:0] RESET_REG = 7'h0F
) (
  input  logic                  clock50,
  input  logic                  i_rst,
  input  logic                  i_scl,
  input  logic                  i_sda,
  output logic                  o_sda_oe,
  output logic                  o_wr_valid,
  output logic [6:0]            o_wr_addr,
  output logic [8:0]            o_wr_data,
  output logic [9*NUM_REGS-1:0] o_regs,
  output logic                  o_busy,
  output logic                  o_frame_err
);
  typedef enum logic [2:0] {IDLE, ADDR, ACK_A, HI, ACK_HI, LO, ACK_LO, WAIT_STOP} state_t;
  state_t state_q, state_d;
  logic [1:0] scl_sync_q, sda_sync_q;
  logic scl_f, sda_f, scl_p_q, sda_p_q;
  logic scl_rise, scl_fall, start, stop, commit;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d, hi_q, hi_d, byte_in;
  logic sda_oe_q, sda_oe_d, busy_q, busy_d, err_q, err_d, wr_valid_q;
  logic [6:0] wr_addr_q, wa;
  logic [8:0] wr_data_q, wd;
  logic [8:0] regs_q [NUM_REGS];

  always_ff @(posedge clock50 or posedge i_rst)
    if (i_rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], i_scl};
      sda_sync_q <= {sda_sync_q[0], i_sda};
    end

`ifdef WM8731_RESP_GLITCH_FILTER_EN
  // A line's filtered value follows the synced value only after 4 consecutive disagreeing samples.
  logic scl_fq, sda_fq;
  logic [1:0] scl_n_q, sda_n_q;
  always_ff @(posedge clock50 or posedge i_rst)
    if (i_rst) begin
      scl_fq  <= 1'b1;
      sda_fq  <= 1'b1;
      scl_n_q <= '0;
      sda_n_q <= '0;
    end else begin
      scl_n_q <= (scl_sync_q[1] == scl_fq) ? 2'd0 : scl_n_q + 2'd1;
      sda_n_q <= (sda_sync_q[1] == sda_fq) ? 2'd0 : sda_n_q + 2'd1;
      scl_fq  <= (scl_sync_q[1] != scl_fq && scl_n_q == 2'd3) ? scl_sync_q[1] : scl_fq;
      sda_fq  <= (sda_sync_q[1] != sda_fq && sda_n_q == 2'd3) ? sda_sync_q[1] : sda_fq;
    end
  assign scl_f = scl_fq;
  assign sda_f = sda_fq;
`else
  assign scl_f = scl_sync_q[1];
  assign sda_f = sda_sync_q[1];
`endif

  assign scl_rise = scl_f & ~scl_p_q;
  assign scl_fall = ~scl_f & scl_p_q;
  assign start    = scl_f & scl_p_q & sda_p_q & ~sda_f;
  assign stop     = scl_f & scl_p_q & ~sda_p_q & sda_f;
  assign byte_in  = {sh_q[6:0], sda_f};
  assign wa       = hi_q[7:1];
  assign wd       = {hi_q[0], sh_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    hi_d     = hi_q;
    sda_oe_d = sda_oe_q;
    busy_d   = busy_q;
    err_d    = err_q;
    commit   = 1'b0;
    if (start) begin
      state_d  = ADDR;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b1;
      err_d    = err_q | (state_q inside {ACK_A, HI, ACK_HI, LO, ACK_LO});
    end else if (stop) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      err_d    = err_q | (state_q inside {HI, ACK_HI, LO});
    end else if (scl_rise && state_q inside {ADDR, HI, LO}) begin
      sh_d  = byte_in;
      cnt_d = cnt_q + 3'd1;
      hi_d  = (cnt_q == 3'd7 && state_q == HI) ? byte_in : hi_q;
      if (cnt_q == 3'd7)
        state_d = state_q == ADDR ? (byte_in == {DEV_ADDR, 1'b0} ? ACK_A : WAIT_STOP) :
                  state_q == HI   ? ACK_HI : ACK_LO;
    end else if (scl_fall && state_q inside {ACK_A, ACK_HI, ACK_LO}) begin
      // First fall drives the ACK, second fall releases SDA and moves on.
      sda_oe_d = ~sda_oe_q;
      if (sda_oe_q) begin
        state_d = state_q == ACK_A ? HI : state_q == ACK_HI ? LO : WAIT_STOP;
        commit  = state_q == ACK_LO;
        err_d   = err_q | (state_q == ACK_LO && int'(wa) >= NUM_REGS && wa != RESET_REG);
      end
    end
  end

  always_ff @(posedge clock50 or posedge i_rst)
    if (i_rst) begin
      state_q    <= IDLE;
      scl_p_q    <= 1'b1;
      sda_p_q    <= 1'b1;
      cnt_q      <= '0;
      sh_q       <= '0;
      hi_q       <= '0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      scl_p_q    <= scl_f;
      sda_p_q    <= sda_f;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      hi_q       <= hi_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      wr_valid_q <= commit;
      if (commit) begin
        wr_addr_q <= wa;
        wr_data_q <= wd;
      end
      for (int k = 0; k < NUM_REGS; k++)
        if (commit && (wa == 7'(k) || wa == RESET_REG)) regs_q[k] <= (wa == 7'(k)) ? wd : 9'd0;
    end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
    assign o_regs[9*i +: 9] = regs_q[i];
  end

  assign o_sda_oe    = sda_oe_q;
  assign o_wr_valid  = wr_valid_q;
  assign o_wr_addr   = wr_addr_q;
  assign o_wr_data   = wr_data_q;
  assign o_busy      = busy_q;
  assign o_frame_err = err_q;
endmodule

// File: tb/tb_wm8731_i2c_responder.sv
// tb_wm8731_i2c_responder: I2C master driving directed and random write frames, checked
// against a register-file model built from the codec's write rules.
module tb_wm8731_i2c_responder;
  localparam int Q = 200;
  logic clock50 = 1'b0, i_rst = 1'b1, scl = 1'b1, sda_m = 1'b1;
  logic o_sda_oe, o_wr_valid, o_busy, o_frame_err;
  logic [6:0] o_wr_addr;
  logic [8:0] o_wr_data;
  logic [89:0] o_regs;
  wire sda_line = sda_m & ~o_sda_oe;
  int n_checks = 0, n_fail = 0, pulses = 0, busy_cycles = 0, m_pulses = 0;
  logic [8:0] m_regs [10];
  logic m_err;
  logic [6:0] m_addr;
  logic [8:0] m_data;

  wm8731_i2c_responder dut (
    .clock50(clock50), .i_rst(i_rst), .i_scl(scl), .i_sda(sda_line),
    .o_sda_oe(o_sda_oe), .o_wr_valid(o_wr_valid), .o_wr_addr(o_wr_addr),
    .o_wr_data(o_wr_data), .o_regs(o_regs), .o_busy(o_busy), .o_frame_err(o_frame_err)
  );

  always #10 clock50 = ~clock50;
  always @(posedge clock50) begin
    if (o_wr_valid) pulses++;
    if (o_busy) busy_cycles++;
  end

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [89:0] m_vec();
    logic [89:0] v;
    for (int k = 0; k < 10; k++) v[9*k +: 9] = m_regs[k];
    return v;
  endfunction

  task automatic m_clear();
    for (int k = 0; k < 10; k++) m_regs[k] = '0;
    m_err = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  task automatic m_write(input logic [6:0] a, input logic [8:0] d);
    int ai;
    ai = int'(a);
    m_pulses++;
    m_addr = a;
    m_data = d;
    if (ai < 10) m_regs[ai] = d;
    else if (ai == 15) for (int k = 0; k < 10; k++) m_regs[k] = '0;
    else m_err = 1'b1;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_pulses"}, 96'(pulses), 96'(m_pulses));
    check({tag, "_regs"}, 96'(o_regs), 96'(m_vec()));
    check({tag, "_err"}, 96'(o_frame_err), 96'(m_err));
    check({tag, "_waddr"}, 96'(o_wr_addr), 96'(m_addr));
    check({tag, "_wdata"}, 96'(o_wr_data), 96'(m_data));
    check({tag, "_busy"}, 96'(o_busy), 96'(0));
    check({tag, "_oe"}, 96'(o_sda_oe), 96'(0));
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; #Q;
    scl = 1'b1; #Q;
    sda_m = 1'b0; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q;
    scl = 1'b1; #Q;
    sda_m = 1'b1; #(4*Q);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sda_m = b[i]; #Q;
      scl = 1'b1; #(2*Q);
      scl = 1'b0; #Q;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    sda_m = 1'b1; #Q;
    scl = 1'b1; #Q;
    ack = ~sda_line; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic frame(input logic [7:0] dev, input logic [6:0] a, input logic [8:0] d, output int acks);
    logic ak;
    acks = 0;
    i2c_start();
    send_byte(dev, ak); acks += int'(ak);
    send_byte({a, d[8]}, ak); acks += int'(ak);
    send_byte(d[7:0], ak); acks += int'(ak);
  endtask

  initial begin
    int acks, b0;
    logic ak;
    logic [7:0] dev;
    logic [6:0] a;
    logic [8:0] d;
    m_clear();
    repeat (3) @(negedge clock50);
    check("rst_valid", 96'(o_wr_valid), 96'(0));
    check_all("reset");
    i_rst = 1'b0;
    repeat (10) @(negedge clock50);

    frame(8'h34, 7'h0F, 9'h000, acks);
    i2c_stop();
    m_write(7'h0F, 9'h000);
    check("t1_acks", 96'(acks), 96'(3));
    check_all("t1");

    frame(8'h34, 7'h04, 9'h012, acks);
    i2c_stop();
    m_write(7'h04, 9'h012);
    check("t2_acks", 96'(acks), 96'(3));
    check("t2_r4", 96'(o_regs[44:36]), 96'(9'h012));
    check_all("t2");

    i2c_start(); send_byte(8'h36, ak); i2c_stop();
    check("t3_ack36", 96'(ak), 96'(0));
    i2c_start(); send_byte(8'h35, ak); i2c_stop();
    check("t3_ack35", 96'(ak), 96'(0));
    check_all("t3");

    frame(8'h34, 7'h07, 9'h0FF, acks);
    m_write(7'h07, 9'h0FF);
    check("t4a_acks", 96'(acks), 96'(3));
    frame(8'h34, 7'h07, 9'h101, acks);
    i2c_stop();
    m_write(7'h07, 9'h101);
    check("t4b_acks", 96'(acks), 96'(3));
    check_all("t4");

    i2c_start(); send_byte(8'h34, ak); send_byte(8'h0C, ak);
    send_bits(8'hA5, 4); i2c_stop();
    m_err = 1'b1;
    check_all("t5");

    b0 = busy_cycles;
    @(negedge clock50);
    sda_m = 1'b0; #60;
    sda_m = 1'b1; #(4*Q);
`ifdef WM8731_RESP_GLITCH_FILTER_EN
    check("t6_busy_seen", 96'(busy_cycles > b0), 96'(0));
`else
    check("t6_busy_seen", 96'(busy_cycles > b0), 96'(1));
`endif
    check_all("t6");

    for (int n = 0; n < 20; n++) begin
      dev = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h34;
      a = 7'($urandom_range(0, 15));
      d = 9'($urandom);
      frame(dev, a, d, acks);
      i2c_stop();
      if (dev == 8'h34) m_write(a, d);
      check("rnd_acks", 96'(acks), 96'(dev == 8'h34 ? 3 : 0));
      check_all("rnd");
    end

    i2c_start();
    send_bits(8'h34, 8);
    sda_m = 1'b1; #Q;
    check("mrst_ack_on", 96'(o_sda_oe), 96'(1));
    i_rst = 1'b1; #1;
    check("mrst_oe", 96'(o_sda_oe), 96'(0));
    #39;
    i_rst = 1'b0;
    m_clear();
    #(2*Q);
    i2c_stop();
    check_all("mrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
